// File: rtl/pswap_stash_if.sv
// Handshake bundle for pswap_stash: forward and backward token channels plus
// the stash occupancy. The master drives tokens in, the slave is the stash.
interface pswap_stash_if #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
);
  logic                     fvalid_in;
  logic                     fcontrol;
  logic [WIDTH-1:0]         fin;
  logic                     fready_out;
  logic [WIDTH-1:0]         fout;
  logic                     fvalid_out;

  logic                     bvalid_in;
  logic [WIDTH-1:0]         bin;
  logic                     bready_out;
  logic [WIDTH-1:0]         bout;
  logic                     bcontrol;
  logic                     bvalid_out;

  logic [$clog2(DEPTH):0]   count_out;

  modport master (
    output fvalid_in, fcontrol, fin, bvalid_in, bin,
    input  fready_out, fout, fvalid_out, bready_out, bout, bcontrol,
           bvalid_out, count_out
  );

  modport slave (
    input  fvalid_in, fcontrol, fin, bvalid_in, bin,
    output fready_out, fout, fvalid_out, bready_out, bout, bcontrol,
           bvalid_out, count_out
  );
endinterface

// File: rtl/pswap_stash.sv
// pswap_stash: forward tokens are optionally bit-reversed under a per-token
// control bit, which is stashed in a FIFO; backward tokens pop that control
// and apply the same (self-inverse) permutation. One-cycle latency each way.
// Optional build macro PSWAP_STASH_STATS_EN adds swap_count_out, a saturating
// count of forward accepts that requested a swap.
module pswap_stash #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  pswap_stash_if.slave      bus
`ifdef PSWAP_STASH_STATS_EN
  ,
  output logic [15:0]       swap_count_out
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Bit-reverse x when c is set; identity otherwise.
  function automatic logic [WIDTH-1:0] perm(input logic [WIDTH-1:0] x,
                                            input logic             c);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
    return c ? r : x;
  endfunction

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             stash_q [DEPTH];
  logic [WIDTH-1:0] fout_q, bout_q;
  logic             bcontrol_q, fvalid_q, bvalid_q;

  logic fready, bready, push, pop, head;

  // Readies depend only on registered occupancy, so a pop at full never frees
  // a slot for a push in the same cycle.
  assign fready = (count_q < CNT_W'(DEPTH));
  assign bready = (count_q != '0);
  assign push   = bus.fvalid_in & fready;
  assign pop    = bus.bvalid_in & bready;
  assign head   = stash_q[rd_ptr_q];

  // Next-state for occupancy and wrapping pointers.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state and registered results, synchronous reset.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_in) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fout_q     <= '0;
      bout_q     <= '0;
      bcontrol_q <= 1'b0;
      fvalid_q   <= 1'b0;
      bvalid_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fvalid_q <= push;
      bvalid_q <= pop;
      if (push) fout_q <= perm(bus.fin, bus.fcontrol);
      if (pop) begin
        bout_q     <= perm(bus.bin, head);
        bcontrol_q <= head;
      end
    end
  end

  // Stash storage write port.
  always_ff @(posedge clk_in) begin
    // NOTE: stash storage is not reset; entries are only read after being written, and the pointers are reset.
    if (push) stash_q[wr_ptr_q] <= bus.fcontrol;
  end

  assign bus.fready_out = fready;
  assign bus.bready_out = bready;
  assign bus.fout       = fout_q;
  assign bus.fvalid_out = fvalid_q;
  assign bus.bout       = bout_q;
  assign bus.bcontrol   = bcontrol_q;
  assign bus.bvalid_out = bvalid_q;
  assign bus.count_out  = count_q;

`ifdef PSWAP_STASH_STATS_EN
  logic [15:0] swap_count_q;

  // Saturating count of accepted forward tokens that requested a swap.
  always_ff @(posedge clk_in) begin
    if (rst_in)
      swap_count_q <= '0;
    else if (push && bus.fcontrol && (swap_count_q != 16'hFFFF))
      swap_count_q <= swap_count_q + 16'd1;
  end

  assign swap_count_out = swap_count_q;
`endif

endmodule

// File: tb/tb_pswap_stash.sv
// Scoreboard bench for pswap_stash: the driver updates a queue-based model of
// the stash and pushes expected results; a negedge monitor pops and compares.
module tb_pswap_stash;
  localparam int WIDTH = 3;
  localparam int DEPTH = 4;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  pswap_stash_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

`ifdef PSWAP_STASH_STATS_EN
  logic [15:0] swap_count_out;
`endif

  pswap_stash #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
`ifdef PSWAP_STASH_STATS_EN
    ,
    .swap_count_out (swap_count_out)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model state
  bit               stash_m[$];
  logic [WIDTH-1:0] fq[$];
  logic [WIDTH:0]   bq[$];
  int               swap_m = 0;

  bit               mon_en = 0;
  bit               rst_seen = 0;
  logic [WIDTH-1:0] last_f, last_b;
  logic             last_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec rule: bit i of x moves to WIDTH-1-i when c=1.
  function automatic logic [WIDTH-1:0] ref_p(input logic [WIDTH-1:0] x, input bit c);
    logic [WIDTH-1:0] r;
    r = {<<{x}};
    return c ? r : x;
  endfunction

  // One clock of stimulus; checks readies/occupancy and records expectations.
  task automatic cycle(input bit fv, input bit fc, input logic [WIDTH-1:0] fi,
                       input bit bv, input logic [WIDTH-1:0] bi);
    bit f_acc, b_acc, c;
    bus.fvalid_in = fv;
    bus.fcontrol  = fc;
    bus.fin       = fi;
    bus.bvalid_in = bv;
    bus.bin       = bi;
    check("fready_out", 32'(bus.fready_out), 32'(stash_m.size() < DEPTH));
    check("bready_out", 32'(bus.bready_out), 32'(stash_m.size() > 0));
    check("count_out",  32'(bus.count_out),  32'(stash_m.size()));
`ifdef PSWAP_STASH_STATS_EN
    check("swap_count_out", 32'(swap_count_out), 32'((swap_m > 65535) ? 65535 : swap_m));
`endif
    f_acc = fv && (stash_m.size() < DEPTH);
    b_acc = bv && (stash_m.size() > 0);
    @(posedge clk_in);
    if (b_acc) begin
      c = stash_m.pop_front();
      bq.push_back({c, ref_p(bi, c)});
    end
    if (f_acc) begin
      stash_m.push_back(fc);
      fq.push_back(ref_p(fi, fc));
      if (fc) swap_m++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    bus.fvalid_in = 1'b0;
    bus.bvalid_in = 1'b0;
    @(posedge clk_in);
    stash_m.delete();
    swap_m = 0;
    #1;
    rst_in = 1'b0;
    mon_en = 1'b1;
  endtask

  always @(posedge clk_in) rst_seen = rst_in;

  // Monitor: compares DUT results against the scoreboard queues.
  always @(negedge clk_in) begin
    if (mon_en) begin
      if (rst_seen) begin
        check("rst fvalid_out", 32'(bus.fvalid_out), 32'd0);
        check("rst bvalid_out", 32'(bus.bvalid_out), 32'd0);
        check("rst fout",       32'(bus.fout),       32'd0);
        check("rst bout",       32'(bus.bout),       32'd0);
        check("rst bcontrol",   32'(bus.bcontrol),   32'd0);
        last_f = '0;
        last_b = '0;
        last_c = 1'b0;
      end else begin
        if (bus.fvalid_out) begin
          check("fvalid_out expected", 32'(bus.fvalid_out), 32'(fq.size() != 0));
          if (fq.size() != 0) check("fout", 32'(bus.fout), 32'(fq.pop_front()));
          last_f = bus.fout;
        end else begin
          check("fout hold", 32'(bus.fout), 32'(last_f));
        end
        if (bus.bvalid_out) begin
          check("bvalid_out expected", 32'(bus.bvalid_out), 32'(bq.size() != 0));
          if (bq.size() != 0) check("bcontrol,bout", 32'({bus.bcontrol, bus.bout}), 32'(bq.pop_front()));
          last_b = bus.bout;
          last_c = bus.bcontrol;
        end else begin
          check("bout hold",     32'(bus.bout),     32'(last_b));
          check("bcontrol hold", 32'(bus.bcontrol), 32'(last_c));
        end
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] exp_bout [4];
    bit               exp_bc   [4];
    exp_bout = '{3'b011, 3'b110, 3'b011, 3'b011};
    exp_bc   = '{1'b1, 1'b0, 1'b1, 1'b1};

    bus.fvalid_in = 1'b0; bus.fcontrol = 1'b0; bus.fin = '0;
    bus.bvalid_in = 1'b0; bus.bin = '0;
    do_reset();

    // Single forward swaps with literal results.
    cycle(1'b1, 1'b1, 3'b100, 1'b0, '0);
    check("fout swap literal", 32'(bus.fout), 32'(3'b001));
    cycle(1'b1, 1'b0, 3'b010, 1'b0, '0);
    check("fout pass literal", 32'(bus.fout), 32'(3'b010));
    cycle(1'b0, 1'b0, '0, 1'b1, '0);
    cycle(1'b0, 1'b0, '0, 1'b1, '0);

    // Push controls 1,0,1,1 then pop four with bin=110.
    for (int i = 0; i < 4; i++) cycle(1'b1, exp_bc[i], 3'($urandom), 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b1, 3'b110);
      check("bout literal",     32'(bus.bout),     32'(exp_bout[i]));
      check("bcontrol literal", 32'(bus.bcontrol), 32'(exp_bc[i]));
    end

    // Fill to full, fifth token refused; pop at full does not admit the push.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'($urandom), 3'($urandom), 1'b0, '0);
    check("count at full", 32'(bus.count_out), 32'd4);
    cycle(1'b1, 1'b1, 3'b011, 1'b1, 3'($urandom));
    cycle(1'b1, 1'b1, 3'b011, 1'b0, '0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1, 3'($urandom));

    // Simultaneous push/pop at count=2 across pointer wrap.
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'($urandom), 3'($urandom), 1'b0, '0);
    for (int i = 0; i < 12; i++)
      cycle(1'b1, 1'($urandom), 3'($urandom), 1'b1, 3'($urandom));
    check("count after pairs", 32'(bus.count_out), 32'd2);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, '0, 1'b1, 3'($urandom));

    // Reset with three controls stashed.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom), 3'($urandom), 1'b0, '0);
    do_reset();
    check("count after reset",  32'(bus.count_out),  32'd0);
    check("bready after reset", 32'(bus.bready_out), 32'd0);
    check("fready after reset", 32'(bus.fready_out), 32'd1);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 2) do_reset();
      else cycle(1'($urandom), 1'($urandom), 3'($urandom),
                 1'($urandom), 3'($urandom));
    end

`ifdef PSWAP_STASH_STATS_EN
    do_reset();
    cycle(1'b1, 1'b1, 3'($urandom), 1'b0, '0);
    for (int i = 0; i < 70000; i++)
      cycle(1'b1, 1'b1, 3'($urandom), 1'b1, 3'($urandom));
    cycle(1'b0, 1'b0, '0, 1'b0, '0);
    check("swap_count saturated", 32'(swap_count_out), 32'h0000FFFF);
`endif

    // Drain and confirm every expected result was observed.
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 1'b0, '0, 1'b1, 3'($urandom));
    cycle(1'b0, 1'b0, '0, 1'b0, '0);
    @(negedge clk_in);
    #1;
    check("fwd scoreboard empty", 32'(fq.size()), 32'd0);
    check("bwd scoreboard empty", 32'(bq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
